// File: rtl/prt_frame_tx.sv
// prt_frame_tx: drains one PRT slot per request onto a byte-wide egress stream.
// Frames longer than FRAME_SIZE are cut (last forced, err_len pulsed) and the
// remainder is read and discarded so the PRT always frees the slot.
// Optional statistics counters are built when PRT_TX_STATS_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high (slot_valid/slot_ready, tx_valid/tx_ready); the valid side holds
// its payload stable until that edge. prt_start_rd and prt_rd_req are
// single-cycle pulses answered later by ack/nack and prt_rd_valid.
`timescale 1ns/1ps
module prt_frame_tx #(
  parameter int INDEX_SIZE = 3,
  parameter int DATA_SIZE  = 8,
  parameter int FRAME_SIZE = 1518,
  parameter int MIN_IFG    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slot_valid,
  input  logic [INDEX_SIZE-1:0] slot_idx,
  output logic                  slot_ready,
  output logic                  prt_start_rd,
  output logic [INDEX_SIZE-1:0] prt_start_slot,
  input  logic                  prt_start_ack,
  input  logic                  prt_start_nack,
  output logic                  prt_rd_req,
  input  logic                  prt_rd_valid,
  input  logic [DATA_SIZE-1:0]  prt_rd_data,
  input  logic                  prt_rd_last,
  output logic                  tx_valid,
  output logic [DATA_SIZE-1:0]  tx_data,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  err_len,
  output logic                  drop,
  output logic [15:0]           frames_sent,
  output logic [31:0]           bytes_sent,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, GAP} state_t;

  localparam logic [15:0] FRAME_LIM = 16'(FRAME_SIZE);
  // The IDLE cycle before slot_ready rises is the last cycle of the gap.
  localparam logic [15:0] GAP_LOAD  = 16'(MIN_IFG - 1);

  state_t                  state_q, state_d;
  logic                    slot_ready_d, start_rd_d, rd_req_d;
  logic [INDEX_SIZE-1:0]   start_slot_d;
  logic                    out_q, out_d;
  logic                    tx_valid_d, tx_last_d;
  logic [DATA_SIZE-1:0]    tx_data_d;
  logic                    tx_eof_q, tx_eof_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [DATA_SIZE-1:0]    pend_data_q, pend_data_d;
  logic                    pend_last_q, pend_last_d;
  logic                    pend_eof_q, pend_eof_d;
  logic                    done_q, done_d;
  logic [15:0]             byte_cnt_q, byte_cnt_d;
  logic [15:0]             gap_cnt_q, gap_cnt_d;
  logic                    err_len_d, drop_d;
  logic                    accept, hs, rsp, tx_free, in_last, go_gap;
  logic [15:0]             in_num;

  assign state_dbg = state_q;

  // Next-state and next-output logic; every target gets a default first.
  always_comb begin
    state_d      = state_q;
    slot_ready_d = 1'b0;
    start_rd_d   = 1'b0;
    start_slot_d = prt_start_slot;
    rd_req_d     = 1'b0;
    out_d        = out_q;
    tx_valid_d   = tx_valid;
    tx_data_d    = tx_data;
    tx_last_d    = tx_last;
    tx_eof_d     = tx_eof_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_last_d  = pend_last_q;
    pend_eof_d   = pend_eof_q;
    done_d       = done_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    err_len_d    = 1'b0;
    drop_d       = 1'b0;
    go_gap       = 1'b0;

    accept  = slot_valid && slot_ready;
    hs      = tx_valid && tx_ready;
    rsp     = prt_rd_valid && out_q;        // stray responses are ignored
    tx_free = !tx_valid || hs;
    // Position in the frame of an arriving byte: accepted + held + 1.
    in_num  = byte_cnt_q + 16'(tx_valid) + 16'(pend_valid_q) + 16'd1;
    in_last = prt_rd_last || (in_num == FRAME_LIM);

    if (hs)  byte_cnt_d = byte_cnt_q + 16'd1;
    if (rsp) out_d = 1'b0;

    case (state_q)
      IDLE: begin
        slot_ready_d = !accept;
        if (accept) begin
          start_slot_d = slot_idx;
          start_rd_d   = 1'b1;
          byte_cnt_d   = 16'd0;
          done_d       = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        if (prt_start_nack) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end else if (prt_start_ack) begin
          rd_req_d = 1'b1;
          out_d    = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        // Egress register refills from the skid entry first, then the PRT.
        if (tx_free) begin
          if (pend_valid_q) begin
            tx_valid_d   = 1'b1;
            tx_data_d    = pend_data_q;
            tx_last_d    = pend_last_q;
            tx_eof_d     = pend_eof_q;
            pend_valid_d = 1'b0;
          end else if (rsp) begin
            tx_valid_d = 1'b1;
            tx_data_d  = prt_rd_data;
            tx_last_d  = in_last;
            tx_eof_d   = prt_rd_last;
          end else begin
            tx_valid_d = 1'b0;
          end
        end
        // A response landing on a stalled register waits in the skid entry.
        if (rsp && !(tx_free && !pend_valid_q)) begin
          pend_valid_d = 1'b1;
          pend_data_d  = prt_rd_data;
          pend_last_d  = in_last;
          pend_eof_d   = prt_rd_last;
        end
        if (rsp && in_last) done_d = 1'b1;
        if (hs && tx_last) begin
          if (tx_eof_q) begin
            go_gap = 1'b1;
          end else begin
            err_len_d = 1'b1;
            rd_req_d  = 1'b1;
            out_d     = 1'b1;
            state_d   = DRAIN;
          end
        end else if (!done_d && !out_d && !pend_valid_d) begin
          rd_req_d = 1'b1;
          out_d    = 1'b1;
        end
      end
      DRAIN: begin
        if (rsp && prt_rd_last) begin
          go_gap = 1'b1;
        end else if (!out_d) begin
          rd_req_d = 1'b1;
          out_d    = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q <= 16'd1) state_d = IDLE;
        else                    gap_cnt_d = gap_cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (go_gap) begin
      if (MIN_IFG <= 1) begin
        state_d = IDLE;
      end else begin
        state_d   = GAP;
        gap_cnt_d = GAP_LOAD;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      slot_ready     <= 1'b0;
      prt_start_rd   <= 1'b0;
      prt_start_slot <= '0;
      prt_rd_req     <= 1'b0;
      out_q          <= 1'b0;
      tx_valid       <= 1'b0;
      tx_data        <= '0;
      tx_last        <= 1'b0;
      tx_eof_q       <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_data_q    <= '0;
      pend_last_q    <= 1'b0;
      pend_eof_q     <= 1'b0;
      done_q         <= 1'b0;
      byte_cnt_q     <= 16'd0;
      gap_cnt_q      <= 16'd0;
      err_len        <= 1'b0;
      drop           <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_ready     <= slot_ready_d;
      prt_start_rd   <= start_rd_d;
      prt_start_slot <= start_slot_d;
      prt_rd_req     <= rd_req_d;
      out_q          <= out_d;
      tx_valid       <= tx_valid_d;
      tx_data        <= tx_data_d;
      tx_last        <= tx_last_d;
      tx_eof_q       <= tx_eof_d;
      pend_valid_q   <= pend_valid_d;
      pend_data_q    <= pend_data_d;
      pend_last_q    <= pend_last_d;
      pend_eof_q     <= pend_eof_d;
      done_q         <= done_d;
      byte_cnt_q     <= byte_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      err_len        <= err_len_d;
      drop           <= drop_d;
    end
  end

`ifdef PRT_TX_STATS_EN
  logic [15:0] frames_q;
  logic [31:0] bytes_q;

  // Wrapping frame/byte counters driven by egress handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_q <= 16'd0;
      bytes_q  <= 32'd0;
    end else begin
      if (hs)            bytes_q  <= bytes_q + 32'd1;
      if (hs && tx_last) frames_q <= frames_q + 16'd1;
    end
  end

  assign frames_sent = frames_q;
  assign bytes_sent  = bytes_q;
`else
  assign frames_sent = 16'd0;
  assign bytes_sent  = 32'd0;
`endif

endmodule

// File: tb/tb_prt_frame_tx.sv
// tb_prt_frame_tx: directed frames through a 1-cycle-latency PRT model, with
// an expected-byte queue checked by an independent egress monitor.
`timescale 1ns/1ps
module tb_prt_frame_tx;

  localparam int IW = 3;
  localparam int DW = 8;
  localparam int FS = 1518;
  localparam int IFG = 12;
`ifdef PRT_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk, rst;
  logic          slot_valid, slot_ready;
  logic [IW-1:0] slot_idx;
  logic          prt_start_rd, prt_start_ack, prt_start_nack;
  logic [IW-1:0] prt_start_slot;
  logic          prt_rd_req, prt_rd_valid, prt_rd_last;
  logic [DW-1:0] prt_rd_data;
  logic          tx_valid, tx_last, tx_ready;
  logic [DW-1:0] tx_data;
  logic          err_len, drop;
  logic [15:0]   frames_sent;
  logic [31:0]   bytes_sent;
  logic [2:0]    state_dbg;

  prt_frame_tx #(.INDEX_SIZE(IW), .DATA_SIZE(DW), .FRAME_SIZE(FS), .MIN_IFG(IFG)) dut (
    .clk(clk), .rst(rst),
    .slot_valid(slot_valid), .slot_idx(slot_idx), .slot_ready(slot_ready),
    .prt_start_rd(prt_start_rd), .prt_start_slot(prt_start_slot),
    .prt_start_ack(prt_start_ack), .prt_start_nack(prt_start_nack),
    .prt_rd_req(prt_rd_req), .prt_rd_valid(prt_rd_valid),
    .prt_rd_data(prt_rd_data), .prt_rd_last(prt_rd_last),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .err_len(err_len), .drop(drop),
    .frames_sent(frames_sent), .bytes_sent(bytes_sent), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0] exp_q[$];   // {last, data}
  int n_checks = 0;
  int n_fail   = 0;
  int len_tab[8];
  bit ok_tab[8];
  int ready_mode = 0;      // 0: tx_ready high, 1: toggles every cycle
  int req_cnt, err_cnt, drop_cnt, hs_cnt;
  int nack_cyc, rdlast_cyc, lasths_cyc, firsths_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int s, input int i);
    return DW'((s * 37 + i * 3 + 1) & 255);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- PRT model (1-cycle responses) ----------------
  initial begin
    logic st_pend, rd_pend;
    int   cur_slot, rd_idx;
    st_pend = 0; rd_pend = 0; cur_slot = 0; rd_idx = 0;
    prt_start_ack = 0; prt_start_nack = 0; prt_rd_valid = 0;
    prt_rd_data = '0; prt_rd_last = 0; tx_ready = 1;
    forever begin
      tick();
      if (!rst) begin
        st_pend = 0; rd_pend = 0;
        prt_start_ack = 0; prt_start_nack = 0; prt_rd_valid = 0; prt_rd_last = 0;
      end else begin
        tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc & 1) != 0);
        prt_start_ack  = st_pend && ok_tab[cur_slot];
        prt_start_nack = st_pend && !ok_tab[cur_slot];
        if (prt_start_nack) nack_cyc = cyc;
        prt_rd_valid = rd_pend;
        prt_rd_data  = rd_pend ? pat(cur_slot, rd_idx) : '0;
        prt_rd_last  = rd_pend && (rd_idx == len_tab[cur_slot] - 1);
        if (rd_pend) begin
          if (prt_rd_last) rdlast_cyc = cyc;
          rd_idx++;
        end
        st_pend = prt_start_rd;
        if (prt_start_rd) begin
          cur_slot = int'(prt_start_slot);
          rd_idx   = 0;
        end
        if (prt_rd_req) begin
          check("one_outstanding", {31'd0, rd_pend}, 32'd0);
          req_cnt++;
        end
        rd_pend = prt_rd_req;
      end
    end
  end

  // ---------------- egress monitor ----------------
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   e;
    prev_stall = 0; prev_data = '0; prev_last = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", {22'd0, tx_valid, tx_last, tx_data}, {22'd0, 1'b1, prev_last, prev_data});
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_byte", {23'd0, tx_last, tx_data}, 32'hdead);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", {23'd0, tx_last, tx_data}, {23'd0, e});
          end
          hs_cnt++;
          if (hs_cnt == 1) firsths_cyc = cyc;
          if (tx_last) lasths_cyc = cyc;
        end else if (tx_valid && exp_q.size() == 0) begin
          check("spurious_valid", {31'd0, tx_valid}, 32'd0);
        end
        if (err_len) err_cnt++;
        if (drop) drop_cnt++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int s);
    int n;
    n = (len_tab[s] > FS) ? FS : len_tab[s];
    for (int i = 0; i < n; i++)
      exp_q.push_back({((i == len_tab[s] - 1) || (i == FS - 1)), pat(s, i)});
  endtask

  task automatic clear_counts;
    req_cnt = 0; err_cnt = 0; drop_cnt = 0; hs_cnt = 0;
    nack_cyc = 0; rdlast_cyc = 0; lasths_cyc = 0; firsths_cyc = 0;
  endtask

  task automatic wait_ready(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (slot_ready) begin
        seen = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_reset_vals;
    check("rst_slot_ready", {31'd0, slot_ready}, 32'd0);
    check("rst_start_rd", {31'd0, prt_start_rd}, 32'd0);
    check("rst_start_slot", {29'd0, prt_start_slot}, 32'd0);
    check("rst_rd_req", {31'd0, prt_rd_req}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_last", {31'd0, tx_last}, 32'd0);
    check("rst_err_len", {31'd0, err_len}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    check("rst_frames", {16'd0, frames_sent}, 32'd0);
    check("rst_bytes", bytes_sent, 32'd0);
  endtask

  // Send one slot, check the start sequence and the slot_ready return time.
  task automatic run_frame(input int s);
    bit seen;
    int n, ref_cyc;
    wait_ready(200, seen);
    check("ready_before_send", {31'd0, seen}, 32'd1);
    clear_counts();
    if (ok_tab[s]) push_frame(s);
    slot_valid = 1'b1;
    slot_idx   = IW'(s);
    tick();
    slot_valid = 1'b0;
    check("start_rd_pulse", {31'd0, prt_start_rd}, 32'd1);
    check("start_slot", {29'd0, prt_start_slot}, s);
    check("ready_low_after_accept", {31'd0, slot_ready}, 32'd0);
    tick();
    check("start_rd_one_cycle", {31'd0, prt_start_rd}, 32'd0);
    tick();
    check("first_req_after_ack", {31'd0, prt_rd_req}, {31'd0, ok_tab[s]});
    wait_ready(5000, seen);
    check("frame_done", {31'd0, seen}, 32'd1);
    n = cyc;
    if (ok_tab[s]) ref_cyc = ((lasths_cyc > rdlast_cyc) ? lasths_cyc : rdlast_cyc) + IFG + 1;
    else           ref_cyc = nack_cyc + 2;
    check("ready_return_cycle", n, ref_cyc);
    check("all_bytes_seen", exp_q.size(), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    len_tab = '{4, 64, 1, 1520, 10, 0, 100, 5};
    ok_tab  = '{1, 1, 1, 1, 1, 0, 1, 1};
    rst = 1'b0; slot_valid = 1'b0; slot_idx = '0;
    clear_counts();
    repeat (3) tick();
    check_reset_vals();
    rst = 1'b1;
    check("ready_low_before_edge", {31'd0, slot_ready}, 32'd0);
    tick();
    check("ready_first_cycle", {31'd0, slot_ready}, 32'd1);

    // 64-byte frame at full rate.
    run_frame(1);
    check("f64_reads", req_cnt, 32'd64);
    check("f64_bytes", hs_cnt, 32'd64);
    check("f64_rate", lasths_cyc - firsths_cyc, 32'd126);
    check("f64_err", err_cnt, 32'd0);
    check("f64_frames_sent", {16'd0, frames_sent}, STATS ? 32'd1 : 32'd0);
    check("f64_bytes_sent", bytes_sent, STATS ? 32'd64 : 32'd0);

    // Nacked start on slot 5.
    run_frame(5);
    check("nack_drop", drop_cnt, 32'd1);
    check("nack_reads", req_cnt, 32'd0);
    check("nack_bytes", hs_cnt, 32'd0);

    // Oversized stored frame: truncate, then drain the tail.
    run_frame(3);
    check("trunc_bytes", hs_cnt, 32'd1518);
    check("trunc_reads", req_cnt, 32'd1520);
    check("trunc_err", err_cnt, 32'd1);

    // Sink stalling every other cycle.
    ready_mode = 1;
    run_frame(4);
    ready_mode = 0;
    check("stall_reads", req_cnt, 32'd10);
    check("stall_bytes", hs_cnt, 32'd10);
    check("stall_frames_sent", {16'd0, frames_sent}, STATS ? 32'd3 : 32'd0);
    check("stall_bytes_sent", bytes_sent, STATS ? 32'd1592 : 32'd0);

    // Reset in the middle of a 100-byte frame.
    wait_ready(200, seen);
    check("ready_before_rst_frame", {31'd0, seen}, 32'd1);
    clear_counts();
    push_frame(6);
    slot_valid = 1'b1;
    slot_idx   = IW'(6);
    tick();
    slot_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (hs_cnt >= 20) break;
      tick();
    end
    check("rst_reach_byte20", {31'd0, (hs_cnt >= 20)}, 32'd1);
    rst = 1'b0;
    #0.5;
    check_reset_vals();
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b1;

    // Three frames after reset: 1 + 64 + 10 bytes.
    run_frame(2);
    check("one_byte_frame", hs_cnt, 32'd1);
    run_frame(1);
    run_frame(4);
    check("final_frames_sent", {16'd0, frames_sent}, STATS ? 32'd3 : 32'd0);
    check("final_bytes_sent", bytes_sent, STATS ? 32'd75 : 32'd0);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
